// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm game lane engines.
package rhythm_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      FALL = 3'd2,
      HIT  = 3'd3,
      MISS = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      GRADE_NONE    = 2'd0,
      GRADE_GOOD    = 2'd1,
      GRADE_PERFECT = 2'd2
   } grade_t;

   localparam int SPR_W = 40;
   localparam int SPR_H = 40;

   localparam logic [7:0] KEY_START   = 8'h2C;
   localparam logic [7:0] KEY_RESTART = 8'h01;

   localparam logic [9:0] SCREEN_W = 10'd640;
   localparam logic [9:0] SCREEN_H = 10'd480;

endpackage

// File: rtl/note_judge.sv
// Combinational hit-window judge on a note's bottom edge; shared by every lane.
module note_judge #(
   parameter logic [9:0] HIT_LO  = 10'd340,
   parameter logic [9:0] HIT_HI  = 10'd400,
   parameter logic [9:0] PERF_LO = 10'd360,
   parameter logic [9:0] PERF_HI = 10'd380,
   parameter logic [9:0] Y_MAX   = 10'd400
) (
   input  logic [10:0] bottom,
   input  logic        press_edge,
   output logic        in_window,
   output logic        in_perfect,
   output logic        past_max
);

   // Window outputs already include the press qualification, so callers only check priority.
   assign past_max   = (bottom >= {1'b0, Y_MAX});
   assign in_window  = press_edge && (bottom >= {1'b0, HIT_LO}) && (bottom < {1'b0, HIT_HI});
   assign in_perfect = in_window && (bottom >= {1'b0, PERF_LO}) && (bottom < {1'b0, PERF_HI});

endmodule

// File: rtl/note_dropper.sv
// Single-lane falling-note engine: delay, fall, judge, hold result until re-arm.
// Optional perfect grading is enabled by defining NOTE_DROPPER_PERFECT_GRADE_EN.
module note_dropper
   import rhythm_pkg::*;
#(
   parameter logic [9:0]    X_START     = 10'd560,
   parameter logic [9:0]    Y_START     = 10'd100,
   parameter logic [9:0]    Y_MAX       = 10'd400,
   parameter logic [5:0]    SPR_H       = 6'd40,
   parameter logic [9:0]    HIT_LO      = 10'd340,
   parameter logic [9:0]    HIT_HI      = 10'd400,
   parameter logic [9:0]    PERF_LO     = 10'd360,
   parameter logic [9:0]    PERF_HI     = 10'd380,
   parameter logic [11:0]   DELAY       = 12'd1200,
   parameter logic [3:0]    SPEED       = 4'd1,
   parameter logic [7:0]    LANE_KEY    = 8'h51,
   parameter logic [7:0]    START_KEY   = KEY_START,
   parameter logic [7:0]    RESTART_KEY = KEY_RESTART,
   parameter logic [1599:0] SPRITE      = '0
) (
   input  logic          frame_clk,
   input  logic          Reset,
   input  logic [7:0]    keycode,
   input  logic [7:0]    keycode_second,
   output logic [9:0]    dropX,
   output logic [9:0]    dropY,
   output logic [1599:0] sprite,
   output logic          visible,
   output logic          hit,
   output logic          miss,
   output logic [1:0]    grade
);

`ifdef NOTE_DROPPER_PERFECT_GRADE_EN
   localparam bit PERFECT_EN = 1'b1;
`else
   localparam bit PERFECT_EN = 1'b0;
`endif

   state_t      state;
   grade_t      grade_q;
   logic [11:0] counter;
   logic        key_prev;

   logic        lane_press;
   logic        press_edge;
   logic        start_press;
   logic        restart_press;
   logic [10:0] bottom;
   logic [10:0] step_y;
   logic [10:0] step_bottom;
   logic [9:0]  y_ceiling;
   logic        in_window;
   logic        in_perfect;
   logic        past_max;

   assign lane_press    = (keycode == LANE_KEY) || (keycode_second == LANE_KEY);
   assign press_edge    = lane_press && !key_prev;
   assign start_press   = (keycode == START_KEY) || (keycode_second == START_KEY);
   assign restart_press = (keycode == RESTART_KEY) || (keycode_second == RESTART_KEY);

   assign bottom      = {1'b0, dropY} + {5'b0, SPR_H};
   assign step_y      = {1'b0, dropY} + {7'b0, SPEED};
   assign step_bottom = step_y + {5'b0, SPR_H};
   assign y_ceiling   = Y_MAX - {4'b0, SPR_H};

   assign dropX  = X_START;
   assign sprite = visible ? SPRITE : '0;
   assign grade  = grade_q;

   note_judge #(
      .HIT_LO  (HIT_LO),
      .HIT_HI  (HIT_HI),
      .PERF_LO (PERF_LO),
      .PERF_HI (PERF_HI),
      .Y_MAX   (Y_MAX)
   ) u_judge (
      .bottom     (bottom),
      .press_edge (press_edge),
      .in_window  (in_window),
      .in_perfect (in_perfect),
      .past_max   (past_max)
   );

   // Restart aborts from any armed state; in FALL a miss outranks a simultaneous hit.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state    <= IDLE;
         dropY    <= Y_START;
         counter  <= '0;
         hit      <= 1'b0;
         miss     <= 1'b0;
         grade_q  <= GRADE_NONE;
         visible  <= 1'b0;
         key_prev <= 1'b0;
      end else begin
         key_prev <= lane_press;
         if (restart_press && (state != IDLE)) begin
            state   <= IDLE;
            dropY   <= Y_START;
            counter <= '0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            grade_q <= GRADE_NONE;
            visible <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  visible <= 1'b0;
                  if (start_press) begin
                     counter <= '0;
                     if (DELAY == 12'd0) begin
                        state   <= FALL;
                        visible <= 1'b1;
                     end else begin
                        state <= WAIT;
                     end
                  end
               end
               WAIT: begin
                  if (counter == DELAY - 12'd1) begin
                     state   <= FALL;
                     visible <= 1'b1;
                  end else begin
                     counter <= counter + 12'd1;
                  end
               end
               FALL: begin
                  if (past_max) begin
                     state   <= MISS;
                     miss    <= 1'b1;
                     visible <= 1'b0;
                  end else if (in_window) begin
                     state   <= HIT;
                     hit     <= 1'b1;
                     visible <= 1'b0;
                     grade_q <= (PERFECT_EN && in_perfect) ? GRADE_PERFECT : GRADE_GOOD;
                  end else if (step_bottom > {1'b0, Y_MAX}) begin
                     dropY <= y_ceiling;
                  end else begin
                     dropY <= step_y[9:0];
                  end
               end
               HIT, MISS: begin
                  visible <= 1'b0;
               end
               default: begin
                  state   <= IDLE;
                  visible <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
